// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for one port of the data-memory arbiter.
// The requester holds every field steady until gnt rises.
interface dmem_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic          lock;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter for the single-port data memory,
// with a bounded lock for atomic multi-cycle sequences.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MAX_LOCK   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_arbiter_if.slave         p0,
  dmem_arbiter_if.slave         p1,
  output logic [DATA_W-1:0]     rdata,
  output logic                  lock_err,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  input  logic [DATA_W-1:0]     rd
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic          r_rr_last;
  logic          w_rr_nx;
  logic          r_rv0;
  logic          r_rv1;
  logic          r_err;
  logic          w_err_nx;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_own;
  logic          w_own_lock;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        ARB: begin
          if (p0.req && p1.req) begin
            w_gnt0 = r_rr_last;
            w_gnt1 = ~r_rr_last;
          end else begin
            w_gnt0 = p0.req;
            w_gnt1 = p1.req;
          end
        end
        LOCK0: w_gnt0 = p0.req;
        LOCK1: w_gnt1 = p1.req;
        default: ;
      endcase
    end
  end

  always_comb begin
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    a        = '0;
    wd       = '0;
    unique case (1'b1)
      w_gnt0: begin
        MemRead  = ~p0.we;
        MemWrite = p0.we;
        a        = p0.addr;
        wd       = p0.wdata;
      end
      w_gnt1: begin
        MemRead  = ~p1.we;
        MemWrite = p1.we;
        a        = p1.addr;
        wd       = p1.wdata;
      end
      default: ;
    endcase
  end

  assign w_own      = (r_state == LOCK1);
  assign w_own_lock = w_own ? p1.lock : p0.lock;

  // r_cnt = locked cycles already completed, entry cycle included
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_rr_nx    = r_rr_last;
    w_err_nx   = 1'b0;
    if (w_gnt0) begin
      w_rr_nx = 1'b0;
    end else if (w_gnt1) begin
      w_rr_nx = 1'b1;
    end
    unique case (r_state)
      ARB: begin
        if (w_gnt0 && p0.lock) begin
          w_state_nx = LOCK0;
          w_cnt_nx   = CW'(1);
        end else if (w_gnt1 && p1.lock) begin
          w_state_nx = LOCK1;
          w_cnt_nx   = CW'(1);
        end
      end
      LOCK0, LOCK1: begin
        if (!w_own_lock) begin
          w_state_nx = ARB;
          w_cnt_nx   = '0;
        end else if (r_cnt == CW'(MAX_LOCK - 1)) begin
          w_state_nx = ARB;
          w_cnt_nx   = '0;
          w_err_nx   = 1'b1;
          w_rr_nx    = w_own;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ARB;
      r_cnt     <= '0;
      r_rr_last <= 1'b1;
      r_rv0     <= 1'b0;
      r_rv1     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_rr_last <= w_rr_nx;
      r_rv0     <= w_gnt0 & ~p0.we;
      r_rv1     <= w_gnt1 & ~p1.we;
      r_err     <= w_err_nx;
    end
  end

  assign p0.gnt    = w_gnt0;
  assign p1.gnt    = w_gnt1;
  assign p0.rvalid = r_rv0;
  assign p1.rvalid = r_rv1;
  assign rdata     = rd;
  assign lock_err  = r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic,
// checked against a cycle-level model of ownership and memory.
module tb_dmem_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int ML = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] rdata;
  logic          lock_err;
  logic          MemRead;
  logic          MemWrite;
  logic [AW-1:0] a;
  logic [DW-1:0] wd;
  logic [DW-1:0] rd;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) m0 ();
  dmem_arbiter_if #(.AW(AW), .DW(DW)) m1 ();

  dmem_arbiter #(
    .DM_ADDRESS(AW),
    .DATA_W    (DW),
    .MAX_LOCK  (ML)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .p0      (m0),
    .p1      (m1),
    .rdata   (rdata),
    .lock_err(lock_err),
    .MemRead (MemRead),
    .MemWrite(MemWrite),
    .a       (a),
    .wd      (wd),
    .rd      (rd)
  );

  function automatic logic [DW-1:0] seed(int i);
    return (i * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  logic [DW-1:0] mem [512];
  bit            mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= seed(i);
      mem_init <= 1'b1;
    end else begin
      if (MemWrite) mem[a] <= wd;
      if (MemRead)  rd     <= mem[a];
    end
  end

  int            nvec = 0;
  int            nerr = 0;
  logic [DW-1:0] smem [512];
  int            own;
  int            held;
  int            last;
  int            eg;
  bit            ev [2];
  bit            eerr;
  logic [DW-1:0] erd;
  bit            obs_g [2];
  bit            obs_err;
  bit            pend [2];

  task automatic chk(string tag, logic [DW-1:0] got,
                     logic [DW-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv(int k, bit r, bit w, bit l,
                     logic [AW-1:0] ad, logic [DW-1:0] d);
    if (k == 0) begin
      m0.req = r; m0.we = w; m0.lock = l;
      m0.addr = ad; m0.wdata = d;
    end else begin
      m1.req = r; m1.we = w; m1.lock = l;
      m1.addr = ad; m1.wdata = d;
    end
  endtask

  task automatic step();
    bit            r [2];
    bit            w [2];
    bit            l [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] dv [2];
    @(negedge clk);
    r[0] = m0.req; w[0] = m0.we; l[0] = m0.lock;
    ad[0] = m0.addr; dv[0] = m0.wdata;
    r[1] = m1.req; w[1] = m1.we; l[1] = m1.lock;
    ad[1] = m1.addr; dv[1] = m1.wdata;
    eg = -1;
    if (rst_n) begin
      if (own >= 0)          eg = r[own] ? own : -1;
      else if (r[0] && r[1]) eg = 1 - last;
      else if (r[0])         eg = 0;
      else if (r[1])         eg = 1;
    end
    obs_g[0] = m0.gnt;
    obs_g[1] = m1.gnt;
    obs_err  = lock_err;
    chk("gnt0", m0.gnt, eg == 0);
    chk("gnt1", m1.gnt, eg == 1);
    chk("rvalid0", m0.rvalid, ev[0]);
    chk("rvalid1", m1.rvalid, ev[1]);
    chk("lock_err", lock_err, eerr);
    if (ev[0] || ev[1]) chk("rdata", rdata, erd);
    chk("MemRead", MemRead, eg >= 0 && !w[eg]);
    chk("MemWrite", MemWrite, eg >= 0 && w[eg]);
    chk("a", a, eg >= 0 ? ad[eg] : '0);
    chk("wd", wd, eg >= 0 ? dv[eg] : '0);
    @(posedge clk);
    if (!rst_n) begin
      own = -1; last = 1; eerr = 0;
      ev[0] = 0; ev[1] = 0;
    end else begin
      eerr = 0; ev[0] = 0; ev[1] = 0;
      if (eg >= 0) begin
        last = eg;
        if (w[eg]) smem[ad[eg]] = dv[eg];
        else begin
          ev[eg] = 1;
          erd    = smem[ad[eg]];
        end
      end
      if (own < 0) begin
        if (eg >= 0 && l[eg]) begin
          own  = eg;
          held = 1;
        end
      end else if (!l[own]) begin
        own = -1;
      end else begin
        held++;
        if (held == ML) begin
          eerr = 1;
          last = own;
          own  = -1;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, '0, '0);
    drv(1, 0, 0, 0, '0, '0);
  endtask

  initial begin
    logic [DW-1:0] v;
    logic [AW-1:0] ra;
    int            n0;
    int            ne;
    int            cyc;
    for (int i = 0; i < 512; i++) smem[i] = seed(i);
    own = -1; held = 0; last = 1;
    ev[0] = 0; ev[1] = 0; eerr = 0; erd = '0;
    rst_n = 1'b0;
    drv(0, 1, 0, 0, 9'h001, '0);
    drv(1, 1, 0, 0, 9'h002, '0);
    @(posedge clk);
    #1;
    repeat (3) step();

    rst_n = 1'b1;
    step();
    chk("first_tie", obs_g[0], 1'b1);
    step();
    idle();
    step();

    drv(0, 1, 1, 0, 9'h005, 32'hDEAD_BEEF);
    step();
    drv(0, 1, 0, 0, 9'h005, '0);
    step();
    chk("single_rv", m0.rvalid, 1'b1);
    chk("single_rd", rdata, 32'hDEAD_BEEF);
    idle();
    step();

    drv(0, 1, 0, 0, 9'h010, '0);
    drv(1, 1, 0, 0, 9'h011, '0);
    repeat (6) step();
    idle();
    step();

    drv(0, 1, 0, 0, 9'h003, '0);
    step();
    v = smem[9'h020] + 1;
    drv(1, 1, 0, 1, 9'h020, '0);
    step();
    chk("lk_g1", obs_g[1], 1'b1);
    drv(1, 1, 1, 0, 9'h020, v);
    step();
    chk("lk_stall0", obs_g[0], 1'b0);
    chk("lk_wr", obs_g[1], 1'b1);
    drv(1, 0, 0, 0, '0, '0);
    step();
    chk("lk_rel", obs_g[0], 1'b1);
    idle();
    step();
    chk("lk_mem", mem[9'h020], v);

    drv(0, 1, 0, 1, 9'h007, '0);
    step();
    n0 = obs_g[0];
    ne = 0;
    drv(1, 1, 0, 0, 9'h008, '0);
    cyc = 0;
    while (!obs_g[1] && cyc < 40) begin
      step();
      n0 += obs_g[0];
      ne += obs_err;
      cyc++;
    end
    chk("to_bound", cyc < 40, 1'b1);
    chk("to_g0", n0, ML);
    chk("to_err", ne, 1);
    chk("to_g1", obs_g[1], 1'b1);
    idle();
    step();

    drv(0, 1, 0, 1, 9'h009, '0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drv(0, 0, 0, 0, '0, '0);
    drv(1, 1, 0, 0, 9'h004, '0);
    step();
    chk("rst_rv0", m0.rvalid, 1'b0);
    chk("rst_g1", obs_g[1], 1'b1);
    idle();
    step();

    pend[0] = 0;
    pend[1] = 0;
    repeat (600) begin
      for (int k = 0; k < 2; k++) begin
        if (eg == k) pend[k] = 0;
        if (!pend[k]) begin
          if ($urandom_range(0, 9) < 6) begin
            ra = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ra = ra | 9'h1F0;
            pend[k] = 1;
            drv(k, 1, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), ra, $urandom);
          end else begin
            drv(k, 0, 0, 1'($urandom_range(0, 1)), '0, '0);
          end
        end
      end
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
